kala_chakra_elastic_pipe: RTL and testbench

//  Parametrised N-stage elastic pipeline: the generalised, depth-configurable successor to the

---
 rtl/kala_chakra_elastic_pipe.sv | 107 ++++++++++
 tb/tb_kala_chakra_elastic_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kala_chakra_elastic_pipe.sv
// kala_chakra_elastic_pipe: depth-configurable elastic pipeline with flush, RAW hazard scoreboard and commit accounting
// Ports: clk, rst (sync, active-high); in_valid/in_ready with in_pc/in_rd/in_wen/in_data from issue;
//   out_valid/out_ready with out_pc/out_rd/out_wen/out_data to commit; flush drops all entries;
//   query_rs1/2 -> hazard_rs1/2; stage_active, occupancy, current_rashi, commit_count report state.
module kala_chakra_elastic_pipe #(
   parameter int NUM_STAGES     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [ADDR_WIDTH-1:0]           in_pc,
   input  logic [REG_ADDR_WIDTH-1:0]       in_rd,
   input  logic                            in_wen,
   input  logic [DATA_WIDTH-1:0]           in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [ADDR_WIDTH-1:0]           out_pc,
   output logic [REG_ADDR_WIDTH-1:0]       out_rd,
   output logic                            out_wen,
   output logic [DATA_WIDTH-1:0]           out_data,
   input  logic                            flush,
   input  logic [REG_ADDR_WIDTH-1:0]       query_rs1,
   input  logic [REG_ADDR_WIDTH-1:0]       query_rs2,
   output logic                            hazard_rs1,
   output logic                            hazard_rs2,
   output logic [NUM_STAGES-1:0]           stage_active,
   output logic [$clog2(NUM_STAGES+1)-1:0] occupancy,
   output logic [$clog2(NUM_STAGES)-1:0]   current_rashi,
   output logic [31:0]                     commit_count
);
   localparam int OW = $clog2(NUM_STAGES+1);
   localparam int RW = $clog2(NUM_STAGES);
   typedef struct packed {
      logic [ADDR_WIDTH-1:0]     pc;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      wen;
      logic [DATA_WIDTH-1:0]     data;
   } ent_t;
   ent_t [NUM_STAGES-1:0] ent_q, ent_d, src_e;
   logic [NUM_STAGES-1:0] vld_q, vld_d, src_v, rdy, ld, live;
   logic                  rdy_c, accept, commit;
   logic [RW-1:0]         rashi_q, rashi_d;
   logic [31:0]           count_q, count_d;
   // Ready ripples back from the output: a stage can load if it is empty or its successor moves.
   always_comb begin
      rdy_c = out_ready;
      rdy = '0;
      for (int k = NUM_STAGES-1; k >= 0; k--) begin
         rdy_c = ~vld_q[k] | rdy_c;
         rdy[k] = rdy_c;
      end
   end
   assign in_ready  = rdy[0] & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = vld_q[NUM_STAGES-1] & ~flush;
   assign commit    = out_valid & out_ready;
   // Stage k is fed by stage k-1; stage 0 is fed by the input port.
   assign src_v = {vld_q[NUM_STAGES-2:0], accept};
   assign src_e = {ent_q[NUM_STAGES-2:0], {in_pc, in_rd, in_wen, in_data}};
   // Payload moves only with a valid entry so idle inputs never reach the registers.
   assign ld    = rdy & src_v & {NUM_STAGES{~flush}};
   assign vld_d = flush ? '0 : (rdy & src_v) | (~rdy & vld_q);
   always_comb begin
      ent_d = ent_q;
      for (int k = 0; k < NUM_STAGES; k++) ent_d[k] = ld[k] ? src_e[k] : ent_q[k];
   end
   // The entry leaving this cycle no longer blocks a reader.
   assign live = vld_q & ~{commit, {(NUM_STAGES-1){1'b0}}};
   always_comb begin
      hazard_rs1 = 1'b0;
      hazard_rs2 = 1'b0;
      occupancy  = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         hazard_rs1 = hazard_rs1 | (live[k] & ent_q[k].wen & (ent_q[k].rd == query_rs1));
         hazard_rs2 = hazard_rs2 | (live[k] & ent_q[k].wen & (ent_q[k].rd == query_rs2));
         occupancy  = occupancy + OW'(vld_q[k]);
      end
      hazard_rs1 = hazard_rs1 & (|query_rs1);
      hazard_rs2 = hazard_rs2 & (|query_rs2);
   end
   assign rashi_d = commit ? (rashi_q == RW'(NUM_STAGES-1) ? '0 : rashi_q + RW'(1)) : rashi_q;
   assign count_d = count_q + 32'(commit);
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= '0;
         ent_q   <= '0;
         rashi_q <= '0;
         count_q <= '0;
      end else begin
         vld_q   <= vld_d;
         ent_q   <= ent_d;
         rashi_q <= rashi_d;
         count_q <= count_d;
      end
   end
   assign stage_active  = vld_q;
   assign current_rashi = rashi_q;
   assign commit_count  = count_q;
   assign out_pc        = ent_q[NUM_STAGES-1].pc;
   assign out_rd        = ent_q[NUM_STAGES-1].rd;
   assign out_wen       = ent_q[NUM_STAGES-1].wen;
   assign out_data      = ent_q[NUM_STAGES-1].data;
endmodule

// File: tb/tb_kala_chakra_elastic_pipe.sv
// tb_kala_chakra_elastic_pipe: directed and randomized checks of the elastic pipe against a queue model
module tb_kala_chakra_elastic_pipe;
   localparam int N = 12, AW = 32, DW = 32, RAW = 5;
   localparam int OW = $clog2(N+1), RW = $clog2(N);
   logic clk = 1'b0, rst, in_valid, in_ready, in_wen, out_valid, out_ready, out_wen, flush;
   logic hazard_rs1, hazard_rs2;
   logic [AW-1:0] in_pc, out_pc;
   logic [DW-1:0] in_data, out_data;
   logic [RAW-1:0] in_rd, out_rd, query_rs1, query_rs2;
   logic [N-1:0] stage_active;
   logic [OW-1:0] occupancy;
   logic [RW-1:0] current_rashi;
   logic [31:0] commit_count;
   int checks = 0, errors = 0;
   typedef struct {
      logic [AW-1:0] pc;
      logic [RAW-1:0] rd;
      logic wen;
      logic [DW-1:0] data;
   } ent_t;

   kala_chakra_elastic_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
      .in_wen(in_wen), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rd(out_rd), .out_wen(out_wen), .out_data(out_data), .flush(flush), .query_rs1(query_rs1),
      .query_rs2(query_rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2), .stage_active(stage_active),
      .occupancy(occupancy), .current_rashi(current_rashi), .commit_count(commit_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle;
      in_valid = 0; in_pc = 0; in_rd = 0; in_wen = 0; in_data = 0; flush = 0; out_ready = 0;
      query_rs1 = 0; query_rs2 = 0;
   endtask

   task automatic do_reset;
      idle; rst = 1; tick; rst = 0;
   endtask

   task automatic test_reset;
      do_reset; #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      checks++; if (stage_active !== '0) begin errors++; $display("FAIL reset_stage_active: got %h want 0", stage_active); end
      checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
      checks++; if (commit_count !== 32'd0) begin errors++; $display("FAIL reset_commit_count: got %0d want 0", commit_count); end
      checks++; if (current_rashi !== '0) begin errors++; $display("FAIL reset_rashi: got %0d want 0", current_rashi); end
      checks++; if ({out_pc, out_rd, out_wen, out_data} !== '0) begin errors++; $display("FAIL reset_payload: got %h want 0", out_pc); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_latency;
      int lat;
      do_reset;
      out_ready = 1; in_valid = 1; in_pc = 32'h100; in_rd = 3; in_wen = 1; in_data = 32'hABCD;
      tick;
      in_valid = 0; lat = 1;
      forever begin
         #1;
         if (out_valid === 1'b1 || lat >= 3*N) break;
         tick; lat++;
      end
      checks++; if (lat != N) begin errors++; $display("FAIL latency: got %0d want %0d", lat, N); end
      checks++; if (out_pc !== 32'h100 || out_data !== 32'hABCD) begin errors++; $display("FAIL latency_payload: got %h/%h want 100/abcd", out_pc, out_data); end
      tick; #1;
      checks++; if (commit_count !== 32'd1) begin errors++; $display("FAIL latency_commit_count: got %0d want 1", commit_count); end
      checks++; if (current_rashi !== RW'(1)) begin errors++; $display("FAIL latency_rashi: got %0d want 1", current_rashi); end
      checks++; if (occupancy !== '0) begin errors++; $display("FAIL latency_occupancy: got %0d want 0", occupancy); end
   endtask

   task automatic test_backpressure;
      int sent = 0, recv = 0, cyc = 0;
      do_reset;
      for (int c = 0; c < 20; c++) begin
         in_valid = 1; in_pc = 32'(4*sent); #1;
         if (in_ready) sent++;
         tick;
      end
      in_pc = 32'(4*sent); #1;
      checks++; if (sent != N) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", sent, N); end
      checks++; if (occupancy !== OW'(N)) begin errors++; $display("FAIL bp_occupancy: got %0d want %0d", occupancy, N); end
      checks++; if (stage_active !== '1) begin errors++; $display("FAIL bp_stage_active: got %h want all ones", stage_active); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %0b want 0", in_ready); end
      out_ready = 1;
      while (recv < 20 && cyc < 100) begin
         in_valid = (sent < 20); in_pc = 32'(4*sent); #1;
         if (out_valid) begin
            checks++; if (out_pc !== 32'(4*recv)) begin errors++; $display("FAIL bp_order: got %h want %h", out_pc, 4*recv); end
            recv++;
         end
         if (in_valid && in_ready) sent++;
         tick; cyc++;
      end
      checks++; if (recv != 20) begin errors++; $display("FAIL bp_drained: got %0d want 20", recv); end
      checks++; if (cyc != 20) begin errors++; $display("FAIL bp_throughput: got %0d cycles want 20", cyc); end
   endtask

   task automatic test_flush;
      do_reset;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; in_pc = 32'(32'h40 + 4*i); tick;
      end
      in_valid = 0;
      repeat (N) tick;
      #1;
      checks++; if (occupancy !== OW'(5)) begin errors++; $display("FAIL flush_prefill: got %0d want 5", occupancy); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_prefill_out_valid: got %0b want 1", out_valid); end
      flush = 1; out_ready = 1; in_valid = 1; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
      tick;
      flush = 0; in_valid = 0; #1;
      checks++; if (occupancy !== '0) begin errors++; $display("FAIL flush_occupancy: got %0d want 0", occupancy); end
      checks++; if (stage_active !== '0) begin errors++; $display("FAIL flush_stage_active: got %h want 0", stage_active); end
      checks++; if (commit_count !== 32'd0) begin errors++; $display("FAIL flush_commit_count: got %0d want 0", commit_count); end
   endtask

   task automatic test_hazard;
      do_reset;
      out_ready = 1; query_rs1 = 7; query_rs2 = 0;
      in_valid = 1; in_rd = 7; in_wen = 1; #1;
      checks++; if (hazard_rs1 !== 1'b0) begin errors++; $display("FAIL hazard_port_excluded: got %0b want 0", hazard_rs1); end
      tick;
      in_rd = 0; in_wen = 1; tick;
      in_valid = 0;
      for (int i = 2; i <= N + 1; i++) begin
         #1;
         checks++; if (hazard_rs1 !== (i < N)) begin errors++; $display("FAIL hazard_rs1 cycle %0d: got %0b want %0b", i, hazard_rs1, i < N); end
         checks++; if (hazard_rs2 !== 1'b0) begin errors++; $display("FAIL hazard_rs2_x0 cycle %0d: got %0b want 0", i, hazard_rs2); end
         tick;
      end
   endtask

   task automatic test_bubbles;
      logic [31:0] expq[$];
      int acc = 0, cyc = 0;
      logic [N-1:0] mask;
      do_reset;
      for (int c = 0; c < 10; c++) begin
         in_valid = $urandom_range(0, 1) | (c == 0); in_pc = 32'(32'h200 + 4*acc); #1;
         if (in_valid && in_ready) begin expq.push_back(in_pc); acc++; end
         tick;
      end
      in_valid = 0;
      repeat (N) tick;
      #1;
      mask = '0;
      for (int i = 0; i < acc; i++) mask[N-1-i] = 1'b1;
      checks++; if (occupancy !== OW'(acc)) begin errors++; $display("FAIL bubble_occupancy: got %0d want %0d", occupancy, acc); end
      checks++; if (stage_active !== mask) begin errors++; $display("FAIL bubble_collapse: got %h want %h", stage_active, mask); end
      out_ready = 1;
      while (expq.size() > 0 && cyc < 50) begin
         #1;
         if (out_valid) begin
            checks++; if (out_pc !== expq[0]) begin errors++; $display("FAIL bubble_order: got %h want %h", out_pc, expq[0]); end
            void'(expq.pop_front());
         end
         tick; cyc++;
      end
      #1;
      checks++; if (expq.size() != 0 || occupancy !== '0) begin errors++; $display("FAIL bubble_drain: got %0d left, occ %0d want 0", expq.size(), occupancy); end
   endtask

   task automatic test_wrap_reset;
      do_reset;
      out_ready = 1;
      for (int c = 0; c < 2*N + 1; c++) begin
         in_valid = (c < N); in_pc = 32'(4*c);
         tick; #1;
         if (c + 1 == 2*N - 1) begin
            checks++; if (current_rashi !== RW'(N-1) || commit_count !== 32'(N-1)) begin errors++; $display("FAIL wrap_pre: got %0d/%0d want %0d/%0d", current_rashi, commit_count, N-1, N-1); end
         end
         if (c + 1 == 2*N) begin
            checks++; if (current_rashi !== '0 || commit_count !== 32'(N)) begin errors++; $display("FAIL wrap: got %0d/%0d want 0/%0d", current_rashi, commit_count, N); end
         end
      end
      for (int c = 0; c < 14; c++) begin
         in_valid = 1; in_pc = 32'(32'h800 + 4*c); tick;
      end
      rst = 1; tick; rst = 0; in_valid = 0; #1;
      checks++; if (stage_active !== '0 || occupancy !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %h/%0d/%0b want 0/0/0", stage_active, occupancy, out_valid); end
      checks++; if (commit_count !== 32'd0 || current_rashi !== '0) begin errors++; $display("FAIL midreset_counters: got %0d/%0d want 0/0", commit_count, current_rashi); end
      checks++; if (out_pc !== '0) begin errors++; $display("FAIL midreset_payload: got %h want 0", out_pc); end
   endtask

   task automatic test_random;
      ent_t q[$];
      ent_t e;
      int ccount = 0, pcn = 0, cyc = 0;
      logic exp_ir, cm, h1, h2;
      do_reset;
      for (int c = 0; c < 600 + 3*N; c++) begin
         if (c < 600) begin
            in_valid = ($urandom_range(0, 99) < 65); flush = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 99) < (((c / 40) % 2) ? 85 : 20));
         end else begin
            in_valid = 0; flush = 0; out_ready = 1;
         end
         in_pc = 32'(pcn); in_rd = RAW'($urandom_range(0, 3)); in_wen = 1'($urandom_range(0, 1)); in_data = $urandom;
         query_rs1 = RAW'($urandom_range(0, 3)); query_rs2 = RAW'($urandom_range(0, 3));
         #1;
         exp_ir = !flush && !(q.size() == N && !out_ready);
         checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL rnd_in_ready c%0d: got %0b want %0b", c, in_ready, exp_ir); end
         checks++; if (occupancy !== OW'(q.size())) begin errors++; $display("FAIL rnd_occupancy c%0d: got %0d want %0d", c, occupancy, q.size()); end
         checks++; if (commit_count !== 32'(ccount)) begin errors++; $display("FAIL rnd_commit_count c%0d: got %0d want %0d", c, commit_count, ccount); end
         checks++; if (current_rashi !== RW'(ccount % N)) begin errors++; $display("FAIL rnd_rashi c%0d: got %0d want %0d", c, current_rashi, ccount % N); end
         checks++; if (out_valid === 1'b1 && (flush || q.size() == 0)) begin errors++; $display("FAIL rnd_spurious_out c%0d: got out_valid 1 want 0", c); end
         cm = out_valid && out_ready && q.size() > 0;
         h1 = 0; h2 = 0;
         for (int i = 0; i < q.size(); i++) begin
            if (!(cm && i == 0) && q[i].wen && q[i].rd == query_rs1) h1 = 1;
            if (!(cm && i == 0) && q[i].wen && q[i].rd == query_rs2) h2 = 1;
         end
         h1 = h1 && query_rs1 != 0; h2 = h2 && query_rs2 != 0;
         checks++; if (hazard_rs1 !== h1 || hazard_rs2 !== h2) begin errors++; $display("FAIL rnd_hazard c%0d: got %0b%0b want %0b%0b", c, hazard_rs1, hazard_rs2, h1, h2); end
         if (flush) q.delete();
         else begin
            if (cm) begin
               e = q.pop_front();
               checks++; if (out_pc !== e.pc || out_rd !== e.rd || out_wen !== e.wen || out_data !== e.data) begin errors++; $display("FAIL rnd_commit_payload c%0d: got %h/%0d/%0b/%h want %h/%0d/%0b/%h", c, out_pc, out_rd, out_wen, out_data, e.pc, e.rd, e.wen, e.data); end
               ccount++;
            end
            if (in_valid && exp_ir) begin
               q.push_back('{pc: in_pc, rd: in_rd, wen: in_wen, data: in_data});
               pcn += 4;
            end
         end
         tick; cyc++;
      end
      #1;
      checks++; if (q.size() != 0 || occupancy !== '0) begin errors++; $display("FAIL rnd_final_drain: got %0d model / %0d dut want 0", q.size(), occupancy); end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      rst = 1;
      idle;
      test_reset;
      test_latency;
      test_backpressure;
      test_flush;
      test_hazard;
      test_bubbles;
      test_wrap_reset;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
